// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expansion, one schedule word per clock,
// streaming 128-bit round keys 0..Nr over a valid/ready handshake.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // entry a sits at bits 2047-8a down, i.e. {~a, 3'b111}
  assign s_o = TBL[{~a_i, 3'b111} -: 8];
endmodule

module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [KEY_BITS-1:0] key_in_i,
  output logic                busy_o,
  output logic                rk_valid_o,
  input  logic                rk_ready_i,
  output logic [127:0]        rk_data_o,
  output logic [3:0]          rk_round_o,
  output logic                done_o
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_e;
  state_e              state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [31:0]         win_q [NK];
  logic [31:0]         win_d [NK];
  logic [31:0]         asm_q [3];
  logic [31:0]         asm_d [3];
  logic [5:0]          idx_q, idx_d;
  logic [2:0]          p_q, p_d;
  logic [7:0]          rcon_q, rcon_d;
  logic                rk_valid_q, rk_valid_d;
  logic [127:0]        rk_data_q, rk_data_d;
  logic [3:0]          rk_round_q, rk_round_d;
  logic                done_q, done_d;
  logic                accept, stall, gen, hs;
  logic [31:0]         prev, sub_in, sub_out, t, new_w;
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a_i(sub_in[8*g +: 8]), .s_o(sub_out[8*g +: 8]));
  end
  always_comb begin
    hs     = rk_valid_q && rk_ready_i;
    accept = state_q == IDLE && start_i;
    // a finished key still waiting for the consumer blocks the word that would overwrite it
    stall  = idx_q[1:0] == 2'd3 && rk_valid_q && !rk_ready_i;
    gen    = (state_q == LOAD || state_q == EXPAND) && !stall;
    prev   = win_q[NK-1];
    sub_in = p_q == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
    t      = p_q == 3'd0 ? sub_out ^ {rcon_q, 24'h0} : (NK == 8 && p_q == 3'd4) ? sub_out : prev;
    new_w  = state_q == LOAD ? key_q[KEY_BITS-1 -: 32] : win_q[0] ^ t;
  end
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    win_d      = win_q;
    asm_d      = asm_q;
    idx_d      = idx_q;
    p_d        = p_q;
    rcon_d     = rcon_q;
    rk_valid_d = rk_valid_q && !rk_ready_i;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    done_d     = 1'b0;
    if (accept) begin
      state_d = LOAD;
      key_d   = key_in_i;
      idx_d   = '0;
      p_d     = '0;
      rcon_d  = 8'h01;
    end
    if (gen) begin
      for (int j = 0; j < NK - 1; j++) win_d[j] = win_q[j+1];
      win_d[NK-1] = new_w;
      key_d = {key_q[KEY_BITS-33:0], 32'h0};
      idx_d = idx_q + 6'd1;
      p_d   = p_q == 3'(NK - 1) ? 3'd0 : p_q + 3'd1;
      if (state_q == EXPAND && p_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      for (int k = 0; k < 3; k++) if (idx_q[1:0] == 2'(k)) asm_d[k] = new_w;
      if (idx_q[1:0] == 2'd3) begin
        rk_valid_d = 1'b1;
        rk_data_d  = {asm_q[0], asm_q[1], asm_q[2], new_w};
        rk_round_d = idx_q[5:2];
      end
      if (state_q == LOAD && idx_q == 6'(NK - 1)) state_d = EXPAND;
      if (idx_q == 6'(NW - 1)) state_d = DRAIN;
    end
    if (state_q == DRAIN && hs) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      for (int j = 0; j < NK; j++) win_q[j] <= '0;
      for (int k = 0; k < 3; k++) asm_q[k] <= '0;
      idx_q      <= '0;
      p_q        <= '0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      win_q      <= win_d;
      asm_q      <= asm_d;
      idx_q      <= idx_d;
      p_q        <= p_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      done_q     <= done_d;
    end
  end
  assign busy_o     = state_q != IDLE;
  assign rk_valid_o = rk_valid_q;
  assign rk_data_o  = rk_data_q;
  assign rk_round_o = rk_round_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: drives all three key sizes against a FIPS-197 style reference model
// (S-box derived from GF(2^8) inversion), with random keys and random backpressure.
module tb_aes_key_schedule;
  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rk_ready = 1'b1;
  int sel = 0;
  logic [255:0] key_bus = '0;
  logic b128, b192, b256, v128, v192, v256, d128, d192, d256;
  logic [127:0] rd128, rd192, rd256;
  logic [3:0] rn128, rn192, rn256;
  logic o_busy, o_valid, o_done;
  logic [127:0] o_data;
  logic [3:0] o_round;
  int errors = 0, checks = 0;
  logic [7:0] sb [256];
  logic [127:0] exp_rk [15];
  logic [127:0] obs_rk [15];
  int last_arr, done_at;
  always #5 clk = ~clk;
  aes_key_schedule #(.KEY_BITS(128)) u128 (.clk(clk), .rst_n(rst_n), .start_i(start && sel == 0),
    .key_in_i(key_bus[255:128]), .busy_o(b128), .rk_valid_o(v128), .rk_ready_i(rk_ready),
    .rk_data_o(rd128), .rk_round_o(rn128), .done_o(d128));
  aes_key_schedule #(.KEY_BITS(192)) u192 (.clk(clk), .rst_n(rst_n), .start_i(start && sel == 1),
    .key_in_i(key_bus[255:64]), .busy_o(b192), .rk_valid_o(v192), .rk_ready_i(rk_ready),
    .rk_data_o(rd192), .rk_round_o(rn192), .done_o(d192));
  aes_key_schedule #(.KEY_BITS(256)) u256 (.clk(clk), .rst_n(rst_n), .start_i(start && sel == 2),
    .key_in_i(key_bus), .busy_o(b256), .rk_valid_o(v256), .rk_ready_i(rk_ready),
    .rk_data_o(rd256), .rk_round_o(rn256), .done_o(d256));
  always_comb begin
    o_busy  = sel == 0 ? b128 : sel == 1 ? b192 : b256;
    o_valid = sel == 0 ? v128 : sel == 1 ? v192 : v256;
    o_done  = sel == 0 ? d128 : sel == 1 ? d192 : d256;
    o_data  = sel == 0 ? rd128 : sel == 1 ? rd192 : rd256;
    o_round = sel == 0 ? rn128 : sel == 1 ? rn192 : rn256;
  end
  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00, x = a, y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) r ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask
  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction
  task automatic model(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) w[i] = key[255 - 32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int k = 1; k < i / nk; k++) rc = gmul(rc, 8'h02);
          t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk == 8 && i % nk == 4) t = subword(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nk + 6; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  // mode 0: ready high, 1: backpressure, 2: stray start at E10, 3: async reset at E20
  task automatic run(input int s, input logic [255:0] key, input int mode);
    int nk = 4 + 2 * s;
    int nr = nk + 6;
    int n = 0, got = 0, arr = 4, lo3 = 0;
    bit rdy, ev;
    sel = s;
    model(key, nk);
    key_bus = key;
    start = 1'b1;
    rk_ready = 1'b1;
    done_at = -1;
    @(negedge clk);
    start = 1'b0;
    forever begin
      if (mode == 3 && n == 20) begin
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {o_busy, o_valid, o_done, o_round, o_data}, '0);
        break;
      end
      chk("done", o_done, n == done_at);
      if (n == done_at) begin
        chk("idle_after_done", {o_busy, o_valid}, 2'b00);
        break;
      end
      ev = got <= nr && n >= arr;
      chk("busy", o_busy, 1'b1);
      chk("valid", o_valid, ev);
      if (ev) begin
        chk("rk_data", o_data, exp_rk[got]);
        chk("rk_round", o_round, got);
      end
      rdy = 1'b1;
      if (mode == 1) begin
        if (got == 3 && ev && lo3 < 7) begin
          rdy = 1'b0;
          lo3++;
        end else if (got != 3) rdy = $urandom_range(0, 2) != 0;
      end
      if (mode == 2 && n == 9) begin
        start = 1'b1;
        key_bus = ~key;
      end
      if (mode == 2 && n == 10) start = 1'b0;
      rk_ready = rdy;
      if (ev && rdy) begin
        obs_rk[got] = o_data;
        got++;
        if (got > nr) done_at = n + 1;
        else arr = arr + 4 > n + 1 ? arr + 4 : n + 1;
      end
      @(negedge clk);
      n++;
      if (n > 400) begin
        chk("cycle_budget", n, 0);
        break;
      end
    end
    rk_ready = 1'b1;
    last_arr = arr;
  endtask
  function automatic logic [255:0] rnd_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction
  initial begin
    build_sbox();
    repeat (2) @(negedge clk);
    chk("reset_128", {b128, v128, d128, rn128, rd128}, '0);
    chk("reset_192", {b192, v192, d192, rn192, rd192}, '0);
    chk("reset_256", {b256, v256, d256, rn256, rd256}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, {K128, 128'h0}, 0);
    chk("aes128_round1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("aes128_round10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("aes128_last_edge", last_arr, 44);
    chk("aes128_done_edge", done_at, 45);
    run(1, {K192, 64'h0}, 0);
    chk("aes192_round12", obs_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("aes192_last_edge", last_arr, 52);
    run(2, K256, 0);
    chk("aes256_round1", obs_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("aes256_round14", obs_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("aes256_last_edge", last_arr, 60);
    run(0, {K128, 128'h0}, 1);
    chk("bp_round10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run(0, {K128, 128'h0}, 2);
    chk("stray_start_round10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run(0, {K128, 128'h0}, 3);
    repeat (2) @(negedge clk);
    chk("held_in_reset", {b128, v128, d128, rn128, rd128}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, {K128, 128'h0}, 0);
    chk("restart_round10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("restart_last_edge", last_arr, 44);
    run(0, {rnd_key()}, 0);
    chk("b2b_last_edge", last_arr, 44);
    run(1, rnd_key(), 1);
    run(2, rnd_key(), 1);
    run(0, rnd_key(), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
